// File: rtl/scan_decoder_pkg.sv
// -----------------------------------------------------------------------------
// scan_decoder_pkg
// Shared types and helpers for the scan_decoder block:
//   mode_e       - DIRECT / SCAN operating mode, also used for the registered
//                  mode that detects SCAN entry
//   num_outputs  - number of decoder outputs for a given select width
//   onecold      - active-low one-of-width pattern, up to 64 outputs
// -----------------------------------------------------------------------------
package scan_decoder_pkg;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  // Largest supported output count (SEL_W up to 6).
  localparam int MAX_OUTPUTS = 64;

  function automatic int num_outputs(input int sel_w);
    return 1 << sel_w;
  endfunction

  // All ones except bit idx, which is cleared when idx is below width.
  // The caller keeps only the low width bits.
  function automatic logic [MAX_OUTPUTS-1:0] onecold(input int idx, input int width);
    logic [MAX_OUTPUTS-1:0] v;
    v = '1;
    if (idx >= 0 && idx < width && idx < MAX_OUTPUTS) begin
      v[idx[5:0]] = 1'b0;
    end
    return v;
  endfunction

endpackage

// File: rtl/scan_decoder_dwell_counter.sv
// -----------------------------------------------------------------------------
// dwell_counter
// Counts enabled cycles spent on the current scan index and flags when the
// index has been held for dwell+1 enabled cycles.
// Ports:
//   clk    in  clock, rising edge
//   rst    in  synchronous active-high reset, clears the count
//   clr    in  clear the count (SCAN entry); has priority over en
//   en     in  count this cycle (decoder enabled and scanning)
//   dwell  in  extra hold cycles per index
//   tick   out en & (cnt >= dwell): the index advances on this edge
// -----------------------------------------------------------------------------
module dwell_counter #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  input  logic [DWELL_W-1:0] dwell,
  output logic               tick
);

  logic [DWELL_W-1:0] cnt_q;
  logic [DWELL_W-1:0] cnt_d;
  logic               done;

  // '>=' rather than '==' so that lowering dwell below the running count
  // advances on the next enabled cycle instead of running the counter round.
  assign done = (cnt_q >= dwell);
  assign tick = en & done;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = done ? '0 : cnt_q + DWELL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of statement order.
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/scan_decoder.sv
// -----------------------------------------------------------------------------
// scan_decoder
// Registered active-low 1-of-2^SEL_W decoder with a 74x138-style enable group
// and an auto-scan mode that steps through every output with a programmable
// dwell time. A mask input turns the decoded output into a minterm hit.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   g1, g2a_n/g2b_n enable group: en = g1 & ~g2a_n & ~g2b_n
//   mode            0 = DIRECT (y_n follows sel), 1 = SCAN (auto-step)
//   sel             DIRECT index, and start index on SCAN entry
//   dwell           extra enabled cycles each index is held in SCAN
//   mask            minterm mask for hit
//   y_n             registered one-cold outputs, all ones when disabled
//   cur_idx         registered index being decoded (updates even when disabled)
//   wrap            one-cycle pulse when SCAN advances from N-1 to 0
//   hit             |(~y_n & mask), combinational from registered y_n and mask
// -----------------------------------------------------------------------------
module scan_decoder
  import scan_decoder_pkg::*;
#(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    g1,
  input  logic                    g2a_n,
  input  logic                    g2b_n,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [DWELL_W-1:0]      dwell,
  input  logic [(1<<SEL_W)-1:0]   mask,
  output logic [(1<<SEL_W)-1:0]   y_n,
  output logic [SEL_W-1:0]        cur_idx,
  output logic                    wrap,
  output logic                    hit
);

  localparam int N = num_outputs(SEL_W);

  logic                   en;
  logic                   entry;
  logic                   cnt_en;
  logic                   tick;
  logic [MAX_OUTPUTS-1:0] oc;

  mode_e                  mode_q,    mode_d;
  logic [N-1:0]           y_n_q,     y_n_d;
  logic [SEL_W-1:0]       cur_idx_q, cur_idx_d;
  logic                   wrap_q,    wrap_d;

  assign en     = g1 & ~g2a_n & ~g2b_n;
  assign entry  = mode & (mode_q == MODE_DIRECT);
  // The counter only runs in steady SCAN; in DIRECT it simply holds.
  assign cnt_en = en & mode & ~entry;

  dwell_counter #(
    .DWELL_W (DWELL_W)
  ) u_dwell_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (entry),
    .en    (cnt_en),
    .dwell (dwell),
    .tick  (tick)
  );

  always_comb begin
    mode_d    = mode ? MODE_SCAN : MODE_DIRECT;
    cur_idx_d = cur_idx_q;
    wrap_d    = 1'b0;

    if (!mode || entry) begin
      cur_idx_d = sel;
    end else if (tick) begin
      // Natural SEL_W-bit overflow gives the N-1 -> 0 wrap.
      cur_idx_d = cur_idx_q + SEL_W'(1);
      wrap_d    = (cur_idx_q == SEL_W'(N - 1));
    end

    // Index and outputs are decoded from the same next index, so y_n and
    // cur_idx always agree whenever an output is low.
    oc    = onecold(int'(cur_idx_d), N);
    y_n_d = en ? oc[N-1:0] : '1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= MODE_DIRECT;
      y_n_q     <= '1;
      cur_idx_q <= '0;
      wrap_q    <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      y_n_q     <= y_n_d;
      cur_idx_q <= cur_idx_d;
      wrap_q    <= wrap_d;
    end
  end

  assign y_n     = y_n_q;
  assign cur_idx = cur_idx_q;
  assign wrap    = wrap_q;
  assign hit     = |(~y_n_q & mask);

endmodule

// File: tb/tb_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_scan_decoder
// Directed bench for scan_decoder (SEL_W=3, DWELL_W=8). A vector table covers
// DIRECT decode, the enable group and hit; hand-written sequences cover scan
// stepping, freeze, dwell changes, SCAN entry while disabled, and reset.
// -----------------------------------------------------------------------------
module tb_scan_decoder;

  logic       clk;
  logic       rst;
  logic       g1, g2a_n, g2b_n;
  logic       mode;
  logic [2:0] sel;
  logic [7:0] dwell;
  logic [7:0] mask;
  logic [7:0] y_n;
  logic [2:0] cur_idx;
  logic       wrap;
  logic       hit;

  int n_vec;
  int n_err;

  scan_decoder #(
    .SEL_W   (3),
    .DWELL_W (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .g1      (g1),
    .g2a_n   (g2a_n),
    .g2b_n   (g2b_n),
    .mode    (mode),
    .sel     (sel),
    .dwell   (dwell),
    .mask    (mask),
    .y_n     (y_n),
    .cur_idx (cur_idx),
    .wrap    (wrap),
    .hit     (hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst, g1, g2a_n, g2b_n, mode;
    logic [2:0] sel;
    logic [7:0] dwell, mask;
    logic [7:0] exp_y_n;
    logic [2:0] exp_idx;
    logic       exp_wrap, exp_hit;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [7:0] ey, input logic [2:0] ei,
                           input logic ew, input logic eh);
    check({name, ".y_n"},     32'(y_n),     32'(ey));
    check({name, ".cur_idx"}, 32'(cur_idx), 32'(ei));
    check({name, ".wrap"},    32'(wrap),    32'(ew));
    check({name, ".hit"},     32'(hit),     32'(eh));
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled at
  // the same offset after the next edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_en(input logic e);
    g1 = e; g2a_n = 1'b0; g2b_n = 1'b0;
  endtask

  function automatic logic [7:0] oc(input int i);
    logic [7:0] v;
    v = 8'hFF;
    v[i[2:0]] = 1'b0;
    return v;
  endfunction

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1; set_en(1'b1); mode = 1'b0; sel = 3'd0; dwell = 8'd0; mask = 8'hFF;

    // ---------------- vector table ----------------
    //                name      rst g1 2a 2b md sel dwell mask   y_n   idx wrap hit
    vecs.push_back('{"reset",   1, 1, 0, 0, 0, 3'd5, 8'd0, 8'hFF, 8'hFF, 3'd0, 0, 0});
    for (int s = 0; s < 8; s++)
      vecs.push_back('{$sformatf("direct%0d", s), 0, 1, 0, 0, 0, 3'(s), 8'd0, 8'hFF,
                       oc(s), 3'(s), 0, 1});
    // DIRECT return to 0 after 7 must not pulse wrap.
    vecs.push_back('{"direct_to0", 0, 1, 0, 0, 0, 3'd0, 8'd0, 8'hFF, 8'hFE, 3'd0, 0, 1});
    vecs.push_back('{"g1_low",     0, 0, 0, 0, 0, 3'd2, 8'd0, 8'hFF, 8'hFF, 3'd2, 0, 0});
    vecs.push_back('{"g2a_high",   0, 1, 1, 0, 0, 3'd3, 8'd0, 8'hFF, 8'hFF, 3'd3, 0, 0});
    vecs.push_back('{"g2b_high",   0, 1, 0, 1, 0, 3'd4, 8'd0, 8'hFF, 8'hFF, 3'd4, 0, 0});
    vecs.push_back('{"hit_sel4",   0, 1, 0, 0, 0, 3'd4, 8'd0, 8'hEF, 8'hEF, 3'd4, 0, 0});
    vecs.push_back('{"hit_sel3",   0, 1, 0, 0, 0, 3'd3, 8'd0, 8'hEF, 8'hF7, 3'd3, 0, 1});
    vecs.push_back('{"hit_dis",    0, 0, 0, 0, 0, 3'd3, 8'd0, 8'hEF, 8'hFF, 3'd3, 0, 0});

    foreach (vecs[i]) begin
      rst = vecs[i].rst; g1 = vecs[i].g1; g2a_n = vecs[i].g2a_n; g2b_n = vecs[i].g2b_n;
      mode = vecs[i].mode; sel = vecs[i].sel; dwell = vecs[i].dwell; mask = vecs[i].mask;
      cycle();
      check_all(vecs[i].name, vecs[i].exp_y_n, vecs[i].exp_idx, vecs[i].exp_wrap,
                vecs[i].exp_hit);
    end
    mask = 8'hFF;

    // ---------------- scan dwell=2 from 5 ----------------
    set_en(1'b1); mode = 1'b1; sel = 3'd5; dwell = 8'd2;
    for (int k = 0; k < 27; k++) begin
      int ei;
      cycle();
      sel = 3'd1;                      // sel only matters on entry
      ei = (5 + k / 3) % 8;
      check_all($sformatf("scan2_k%0d", k), oc(ei), 3'(ei), (k == 9), 1'b1);
    end

    // ---------------- freeze mid-hold ----------------
    mode = 1'b0; sel = 3'd0; cycle();
    mode = 1'b1; sel = 3'd2; dwell = 8'd2;
    cycle(); check_all("frz_entry", oc(2), 3'd2, 0, 1);
    cycle(); check_all("frz_hold1", oc(2), 3'd2, 0, 1);
    g1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cycle(); check_all($sformatf("frz_off%0d", k), 8'hFF, 3'd2, 0, 0);
    end
    g1 = 1'b1;
    cycle(); check_all("frz_rest", oc(2), 3'd2, 0, 1);
    cycle(); check_all("frz_adv",  oc(3), 3'd3, 0, 1);
    // Leaving SCAN: y_n follows sel on the next edge.
    mode = 1'b0; sel = 3'd6;
    cycle(); check_all("leave_scan", oc(6), 3'd6, 0, 1);

    // ---------------- dwell reduction, then dwell=0 ----------------
    mode = 1'b1; sel = 3'd0; dwell = 8'd10;
    cycle(); check_all("red_entry", oc(0), 3'd0, 0, 1);   // cnt = 0
    for (int k = 0; k < 6; k++) cycle();                   // cnt -> 6
    check_all("red_cnt6", oc(0), 3'd0, 0, 1);
    dwell = 8'd3;
    cycle(); check_all("red_adv", oc(1), 3'd1, 0, 1);
    dwell = 8'd0;
    for (int k = 0; k < 16; k++) begin
      int ei;
      cycle();
      ei = (2 + k) % 8;
      check_all($sformatf("dw0_k%0d", k), oc(ei), 3'(ei), (ei == 0), 1'b1);
    end

    // ---------------- SCAN entry while disabled ----------------
    mode = 1'b0; cycle();
    mode = 1'b1; sel = 3'd4; dwell = 8'd1; g1 = 1'b0;
    cycle(); check_all("entry_dis", 8'hFF, 3'd4, 0, 0);
    g1 = 1'b1;
    cycle(); check_all("entry_dis_c0", oc(4), 3'd4, 0, 1);  // cnt 0 -> 1
    cycle(); check_all("entry_dis_adv", oc(5), 3'd5, 0, 1);

    // ---------------- reset mid-scan ----------------
    mode = 1'b0; cycle();
    mode = 1'b1; sel = 3'd5; dwell = 8'd0;
    cycle(); check_all("rst_pre5", oc(5), 3'd5, 0, 1);
    cycle(); check_all("rst_pre6", oc(6), 3'd6, 0, 1);
    rst = 1'b1;
    cycle(); check_all("rst_mid", 8'hFF, 3'd0, 0, 0);
    rst = 1'b0; sel = 3'd3;                                  // mode held at 1
    cycle(); check_all("rst_reentry", oc(3), 3'd3, 0, 1);
    cycle(); check_all("rst_resume", oc(4), 3'd4, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Backstop against a stalled run.
  initial begin
    #100000;
    $display("FAIL timeout: got no end of test, expected finish within 100000 time units");
    $fatal(1);
  end

endmodule
